spi_slave_frame_ctrl: RTL and testbench
=======================================

Name: spi_slave_frame_ctrl

Overview:
Parametrised SPI slave front-end. It deserialises MOSI command frames of 2 command bits plus DATA_W payload bits into rx_data. For read-data commands it waits for the memory's tx_valid and serialises tx_data onto MISO. Compared with the 8-bit fixed slave it adds a generic width, a single-cycle rx_valid strobe, a tx_valid wait timeout and abort detection. It sits between the SPI pins (clk is the SPI clock domain) and the SPI RAM wrapper.

Parameters:
DATA_W, 8, payload width; frame width FRAME_W = DATA_W+2.
TX_TIMEOUT, 16, max cycles to wait for tx_valid after a read-data frame; range 1..255.

Ports:
clk  in  1  clock; all logic on posedge; MOSI sampled on posedge.
rst_n  in  1  reset; asynchronous assert, active-low.
SS_n  in  1  slave select, active-low.
MOSI  in  1  serial data in, MSB first.
MISO  out  1  serial data out, MSB first; 0 when not shifting.
rx_data  out  FRAME_W  last complete frame {cmd[1:0], payload}.
rx_valid  out  1  one-cycle strobe: rx_data updated.
tx_data  in  DATA_W  read data from memory.
tx_valid  in  1  tx_data valid; sampled only while awaiting read data.
busy  out  1  high whenever state != IDLE.
frame_err  out  1  one-cycle pulse: SS_n rose before frame/readback completed.
tx_timeout  out  1  one-cycle pulse: tx_valid not seen within TX_TIMEOUT cycles.
parity_err  out  1  one-cycle pulse on bad parity (macro only; tied 0 otherwise).

Behaviour:
- Reset (rst_n=0, async): state=IDLE; rx_data=0, rx_valid=0, MISO=0, frame_err=0, tx_timeout=0, parity_err=0; read_pending=0; bit/timeout counters cleared.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 -> CHK_CMD. No bit is captured in this cycle.
- CHK_CMD: captures MOSI as frame bit FRAME_W-1.
  - SS_n=1 -> IDLE.
  - MOSI=0 -> WRITE.
  - MOSI=1 and read_pending=0 -> READ_ADD.
  - MOSI=1 and read_pending=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA shift the remaining FRAME_W-1 bits, one per cycle, MSB first.
- On the cycle the last bit is sampled: rx_data <= assembled frame (registered) and rx_valid=1 for exactly one cycle, next cycle.
- Latency: SS_n low at cycle 0 -> rx_valid high at cycle FRAME_W+1.
- READ_ADD frame complete: read_pending <= 1.
- READ_DATA after frame complete: wait for tx_valid; the timeout counter starts the cycle after rx_valid.
  - First cycle tx_valid=1: latch tx_data. MISO drives tx_data[DATA_W-1] on the next cycle, then one bit per cycle for DATA_W cycles, then returns to 0.
  - Readback complete: read_pending <= 0.
  - tx_valid ignored outside this wait window.
  - Timeout (counter reaches TX_TIMEOUT with no tx_valid): tx_timeout pulse; read_pending <= 0; MISO stays 0.
- After frame/readback completes, the FSM stays in its state ignoring MOSI until SS_n=1.
- Any state except IDLE with SS_n=1 -> IDLE next cycle. SS_n has priority over all other events.
  - frame_err pulses if the frame was incomplete or MISO readback unfinished.
  - Partial frame discarded: rx_data unchanged, no rx_valid, read_pending unchanged.
- tx_valid arriving on the same cycle SS_n rises: ignored; frame_err pulses.
- Counters sized $clog2(FRAME_W+1) and 8 bits; no wrap-around possible within a frame.

Optional Feature:
SPI_SLV_PARITY_EN:
- Defined:
  - Every MOSI frame carries one extra trailing even-parity bit covering all FRAME_W bits.
  - On parity mismatch: parity_err pulses instead of rx_valid, rx_data unchanged, read_pending unchanged.
  - MISO readback appends an even-parity bit after tx_data LSB (DATA_W+1 bits).
  - Latency to rx_valid becomes FRAME_W+2.
- Undefined: no parity bits; parity_err tied 0.

Test Plan:
- DATA_W=8, write frame 0b00_1010_0101 -> rx_valid one cycle at cycle 11, rx_data=10'h0A5, read_pending=0.
- Read-address 10'h2_3C then read-data 10'h3_00; tx_valid with tx_data=8'hC3 -> MISO shows 1,1,0,0,0,0,1,1 on consecutive cycles, then 0; read_pending back to 0.
- Read-data frame with tx_valid never asserted, TX_TIMEOUT=16 -> tx_timeout pulse 16 cycles after rx_valid; MISO=0; next MOSI=1 command goes to READ_ADD.
- SS_n raised after 5 bits of write frame -> frame_err pulse, no rx_valid, rx_data holds previous value, state IDLE next cycle.
- rst_n pulsed low mid-readback -> all outputs 0 immediately (async); after release a read command goes to READ_ADD.
- With SPI_SLV_PARITY_EN, frame 10'h0A5 with wrong parity bit -> parity_err pulse, no rx_valid; correct parity -> rx_valid at cycle 12.

Source files
------------

// File: rtl/spi_slave_frame_ctrl.sv
// SPI slave frame controller: deserialises {cmd[1:0], payload} MOSI frames and serialises read data on MISO.
// Latency: SS_n low in cycle 0 -> rx_valid in cycle FRAME_W+1 (FRAME_W+2 with SPI_SLV_PARITY_EN).
// No backpressure: rx_valid is a strobe; read data waits for tx_valid up to TX_TIMEOUT cycles.
module spi_slave_frame_ctrl #(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              busy,
    output logic              frame_err,
    output logic              tx_timeout,
    output logic              parity_err
);
    localparam int FRAME_W = DATA_W + 2;
`ifdef SPI_SLV_PARITY_EN
    localparam int RX_BITS = FRAME_W + 1;
    localparam int TX_BITS = DATA_W + 1;
    localparam int SH_W    = FRAME_W;
`else
    localparam int RX_BITS = FRAME_W;
    localparam int TX_BITS = DATA_W;
    localparam int SH_W    = FRAME_W - 1;
`endif
    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(RX_BITS - 1);
    localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(TX_BITS);
    localparam logic [7:0]       TMO_LAST = 8'(TX_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           tmo_q, tmo_d;
    logic [SH_W-1:0]      sh_q, sh_d;
    logic [TX_BITS-2:0]   tx_sh_q, tx_sh_d;
    logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 miso_q, miso_d;
    logic                 frame_err_q, frame_err_d;
    logic                 tx_timeout_q, tx_timeout_d;
    logic                 parity_err_q, parity_err_d;
    logic                 read_pending_q, read_pending_d;
    logic                 done_q, done_d;
    logic                 wait_q, wait_d;
    logic                 shift_q, shift_d;

    logic [FRAME_W-1:0]   rx_word;
    logic                 rx_ok;
    logic [TX_BITS-1:0]   tx_word;

`ifdef SPI_SLV_PARITY_EN
    assign rx_word = sh_q;
    assign rx_ok   = ~(^{sh_q, MOSI});
    assign tx_word = {tx_data, ^tx_data};
`else
    assign rx_word = {sh_q, MOSI};
    assign rx_ok   = 1'b1;
    assign tx_word = tx_data;
`endif

    // done_q: frame/readback finished, MOSI ignored until SS_n rises.
    // wait_q / shift_q: READ_DATA sub-phases after its frame completes.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tmo_d          = tmo_q;
        sh_d           = sh_q;
        tx_sh_d        = tx_sh_q;
        rx_data_d      = rx_data_q;
        read_pending_d = read_pending_q;
        done_d         = done_q;
        wait_d         = wait_q;
        shift_d        = shift_q;
        rx_valid_d     = 1'b0;
        miso_d         = 1'b0;
        frame_err_d    = 1'b0;
        tx_timeout_d   = 1'b0;
        parity_err_d   = 1'b0;

        if (state_q != IDLE && SS_n) begin
            state_d     = IDLE;
            frame_err_d = ~done_q;
            cnt_d       = '0;
            tmo_d       = '0;
            done_d      = 1'b0;
            wait_d      = 1'b0;
            shift_d     = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!SS_n) state_d = CHK_CMD;
                end
                CHK_CMD: begin
                    sh_d  = {{(SH_W-1){1'b0}}, MOSI};
                    cnt_d = CNT_W'(1);
                    if (!MOSI)               state_d = WRITE;
                    else if (read_pending_q) state_d = READ_DATA;
                    else                     state_d = READ_ADD;
                end
                default: begin
                    if (done_q) begin
                        state_d = state_q;
                    end else if (wait_q) begin
                        if (tx_valid) begin
                            wait_d  = 1'b0;
                            shift_d = 1'b1;
                            miso_d  = tx_word[TX_BITS-1];
                            tx_sh_d = tx_word[TX_BITS-2:0];
                            cnt_d   = CNT_W'(1);
                        end else if (tmo_q == TMO_LAST) begin
                            wait_d         = 1'b0;
                            done_d         = 1'b1;
                            tx_timeout_d   = 1'b1;
                            read_pending_d = 1'b0;
                        end else begin
                            tmo_d = tmo_q + 1'b1;
                        end
                    end else if (shift_q) begin
                        if (cnt_q == TX_LAST) begin
                            shift_d        = 1'b0;
                            done_d         = 1'b1;
                            read_pending_d = 1'b0;
                        end else begin
                            miso_d  = tx_sh_q[TX_BITS-2];
                            tx_sh_d = tx_sh_q << 1;
                            cnt_d   = cnt_q + 1'b1;
                        end
                    end else if (cnt_q == RX_LAST) begin
                        if (rx_ok) begin
                            rx_data_d  = rx_word;
                            rx_valid_d = 1'b1;
                            if (state_q == READ_ADD) read_pending_d = 1'b1;
                        end else begin
                            parity_err_d = 1'b1;
                        end
                        if (state_q == READ_DATA && rx_ok) begin
                            wait_d = 1'b1;
                            tmo_d  = '0;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else begin
                        sh_d  = {sh_q[SH_W-2:0], MOSI};
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            tmo_q          <= '0;
            sh_q           <= '0;
            tx_sh_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            miso_q         <= 1'b0;
            frame_err_q    <= 1'b0;
            tx_timeout_q   <= 1'b0;
            parity_err_q   <= 1'b0;
            read_pending_q <= 1'b0;
            done_q         <= 1'b0;
            wait_q         <= 1'b0;
            shift_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            sh_q           <= sh_d;
            tx_sh_q        <= tx_sh_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            miso_q         <= miso_d;
            frame_err_q    <= frame_err_d;
            tx_timeout_q   <= tx_timeout_d;
            parity_err_q   <= parity_err_d;
            read_pending_q <= read_pending_d;
            done_q         <= done_d;
            wait_q         <= wait_d;
            shift_q        <= shift_d;
        end
    end

    assign MISO       = miso_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign busy       = (state_q != IDLE);
    assign frame_err  = frame_err_q;
    assign tx_timeout = tx_timeout_q;
    assign parity_err = parity_err_q;
endmodule

// File: tb/tb_spi_slave_frame_ctrl.sv
// Bench for spi_slave_frame_ctrl: directed plus random SPI transactions against a
// transaction-level timing model (frame, abort cycle, tx_valid delay -> expected outputs per cycle).
module tb_spi_slave_frame_ctrl;
    localparam int DW  = 8;
    localparam int F   = DW + 2;
    localparam int TMO = 16;
    localparam int R   = F + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          SS_n = 1'b1;
    logic          MOSI = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          MISO, rx_valid, busy, frame_err, tx_timeout, parity_err;
    logic [F-1:0]  rx_data;

    int           n_chk = 0;
    int           n_err = 0;
    int           txn = 0;
    logic [F-1:0] rx_m = '0;
    bit           pend_m = 1'b0;

    always #5 clk = ~clk;

    spi_slave_frame_ctrl #(.DATA_W(DW), .TX_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
        .busy(busy), .frame_err(frame_err), .tx_timeout(tx_timeout), .parity_err(parity_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " MISO"}, 32'(MISO), 0);
        chk({tag, " rx_data"}, 32'(rx_data), 0);
        chk({tag, " rx_valid"}, 32'(rx_valid), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " frame_err"}, 32'(frame_err), 0);
        chk({tag, " tx_timeout"}, 32'(tx_timeout), 0);
        chk({tag, " parity_err"}, 32'(parity_err), 0);
    endtask

    // SS_n low in cycle 0, frame bits in cycles 1..F, SS_n high from cycle a on.
    // d>0: tx_valid in cycle R+d; d==0: tx_valid never sent. rst_at>=0 pulses reset in that cycle.
    task automatic run_txn(input logic [F-1:0] frame, input int a, input int d,
                           input logic [DW-1:0] txd, input int gap, input int rst_at);
        bit rd_data = frame[F-1] && pend_m;
        bit rd_add  = frame[F-1] && !pend_m;
        bit fr_done = (a >= F + 1);
        int T = R + d;
        bit to_hit = 1'b0;
        bit incomplete;
        bit noise_ok;
        string tg;
        if (rd_data && d > 0)  incomplete = (a < T + 9);
        else if (rd_data) begin
            to_hit     = (a >= R + 16);
            incomplete = !to_hit;
        end else incomplete = !fr_done;
        txn++;
        for (int c = 0; c <= a + gap; c++) begin
            SS_n     = (c >= a);
            MOSI     = (c >= 1 && c <= F) ? frame[F-c] : 1'($urandom);
            tx_data  = DW'($urandom);
            noise_ok = !rd_data || c <= F || c >= a || (d > 0 && c > T) || (d == 0 && c >= R + 16);
            tx_valid = noise_ok ? 1'($urandom) : 1'b0;
            if (rd_data && d > 0 && c == T) begin
                tx_valid = 1'b1;
                tx_data  = txd;
            end
            if (c == rst_at) begin
                #2 rst_n = 1'b0;
                #1 chk_all_zero($sformatf("t%0d rst", txn));
                @(posedge clk);
                #1;
                SS_n     = 1'b1;
                tx_valid = 1'b0;
                rst_n    = 1'b1;
                @(posedge clk);
                #1;
                rx_m   = '0;
                pend_m = 1'b0;
                return;
            end
            @(negedge clk);
            tg = $sformatf("t%0d c%0d", txn, c);
            chk({tg, " busy"}, 32'(busy), 32'(c >= 1 && c <= a));
            chk({tg, " rx_valid"}, 32'(rx_valid), 32'(fr_done && c == F + 1));
            chk({tg, " rx_data"}, 32'(rx_data), 32'((fr_done && c >= F + 1) ? frame : rx_m));
            chk({tg, " frame_err"}, 32'(frame_err), 32'(incomplete && c == a + 1));
            chk({tg, " tx_timeout"}, 32'(tx_timeout), 32'(to_hit && c == R + 16));
            chk({tg, " MISO"}, 32'(MISO),
                32'((rd_data && d > 0 && c >= T + 1 && c <= T + 8 && c <= a) ? txd[T+8-c] : 1'b0));
            chk({tg, " parity_err"}, 32'(parity_err), 0);
            @(posedge clk);
            #1;
        end
        if (fr_done) rx_m = frame;
        if (rd_add && fr_done) pend_m = 1'b1;
        if (rd_data && !incomplete) pend_m = 1'b0;
    endtask

    initial begin
        logic [F-1:0] fr;
        int a, d, r;
        bit rd;
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_txn(10'h0A5, F + 3, 0, 8'h00, 2, -1);          // write frame
        run_txn(10'h23C, F + 20, 0, 8'h00, 2, -1);         // read address, no wait
        run_txn(10'h300, R + 3 + 10, 3, 8'hC3, 2, -1);     // readback C3
        run_txn(10'h2AA, F + 2, 0, 8'h00, 1, -1);
        run_txn(10'h300, R + 18, 0, 8'h00, 2, -1);         // tx_valid timeout
        run_txn(10'h311, F + 20, 0, 8'h00, 2, -1);         // routed to READ_ADD
        run_txn(10'h0FF, 6, 0, 8'h00, 2, -1);              // abort after 5 bits
        run_txn(10'h35A, R + 15 + 10, 15, 8'h96, 2, -1);   // tx_valid on last allowed cycle
        run_txn(10'h2F0, F + 2, 0, 8'h00, 1, -1);
        run_txn(10'h30F, R + 5, 5, 8'hA5, 2, -1);          // tx_valid with SS_n rising
        run_txn(10'h3FF, 40, 2, 8'h5A, 2, R + 2 + 3);      // reset mid-readback
        run_txn(10'h3C3, F + 20, 0, 8'h00, 2, -1);         // after reset -> READ_ADD

        for (int i = 0; i < 60; i++) begin
            fr = F'($urandom);
            d  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
            rd = fr[F-1] && pend_m;
            r  = $urandom_range(0, 7);
            if (!rd)        a = (r == 0) ? $urandom_range(1, F) : F + 1 + $urandom_range(0, (r == 1) ? 20 : 3);
            else if (d > 0) a = (r == 0) ? $urandom_range(1, F)
                              : (r == 1) ? $urandom_range(F + 1, R + d + 8) : R + d + 9 + $urandom_range(0, 2);
            else            a = (r == 0) ? $urandom_range(1, F)
                              : (r == 1) ? $urandom_range(F + 1, R + 15) : R + 16 + $urandom_range(0, 2);
            run_txn(fr, a, d, DW'($urandom), $urandom_range(1, 3), -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
